uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter among NUM_REQ mode blocks (input, generate, display, compute).
//  Each mode offers bytes via a valid/ready handshake; the arbiter grants one message at a time, round-robin.
//  A grant is locked until the owner's byte tagged req_last has been handed to the transmitter.
//  Sits between the mode modules and the UART TX core, in the top-level controller.
// PARAMETERS
//  NUM_REQ         4     number of requesters (2..8)
//  ID_W            2     width of grant_id, >= clog2(NUM_REQ)
//  TIMEOUT_CYCLES  1024  idle-owner release limit (used only with TX_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1            system clock, all logic on rising edge
//  rst_n        in   1            asynchronous, active-low reset
//  req_valid    in   NUM_REQ      requester i has a byte on req_data[8i+:8]
//  req_data     in   8*NUM_REQ    packed bytes, requester i at bits [8i+7:8i]
//  req_last     in   NUM_REQ      byte currently offered by requester i ends its message
//  req_ready    out  NUM_REQ      one-cycle pulse: byte of requester i consumed
//  tx_data      out  8            byte to UART TX core
//  tx_start     out  1            one-cycle start pulse to UART TX core
//  tx_busy      in   1            UART TX core busy
//  grant_valid  out  1            a requester currently owns the transmitter
//  grant_id     out  ID_W         index of current owner (valid when grant_valid=1)
//  timeout_err  out  1            one-cycle pulse: grant force-released (0 without macro)
// BEHAVIOUR
//  Reset: req_ready=0, tx_data=0, tx_start=0, grant_valid=0, grant_id=0, timeout_err=0,
//   rr_ptr=NUM_REQ-1 (requester 0 wins the first contest), state=IDLE. Reset mid-transfer drops tx_start at once.
//  States IDLE, LOCKED, ISSUE_WAIT:
//  IDLE: if any req_valid, choose first set bit scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ);
//   next cycle grant_valid=1, grant_id=winner, state=LOCKED. No byte is sent in the arbitration cycle.
//  LOCKED: when req_valid[grant_id]=1 and tx_busy=0: register tx_data=req_data[owner], tx_start=1 and
//   req_ready[grant_id]=1 for exactly one cycle; latch last_flag=req_last[owner]; state=ISSUE_WAIT.
//  ISSUE_WAIT: leave when tx_busy=1 or after 2 cycles in state (guards against a late busy rise and
//   double issue). If last_flag=1: rr_ptr=grant_id, grant_valid=0, state=IDLE; else state=LOCKED.
//  Throughput: at most one byte per UART frame; LOCKED->tx_start latency 1 cycle after tx_busy falls.
//  Non-owner req_valid is ignored; req_ready of non-owners stays 0. req_last is sampled only with
//   an accepted byte. At most one req_ready bit is high in any cycle.
//  Owner dropping req_valid mid-message: grant held indefinitely (message framing preserved).
//  Simultaneous requests in IDLE: round-robin order, so the just-released owner has lowest priority.
//  Requester asserting valid with last on its first byte: single-byte message, released after issue.
//  tx_busy already high on entry to LOCKED: wait, no issue until it falls.
// CONFIGURATION
//  TX_ARB_TIMEOUT_EN defined: counter runs in LOCKED while req_valid[grant_id]=0, cleared on any
//   accepted byte; on reaching TIMEOUT_CYCLES: grant_valid=0, rr_ptr=grant_id, timeout_err pulses 1 cycle,
//   state=IDLE. Counter is clog2(TIMEOUT_CYCLES)+1 bits, reset to 0.
//  TX_ARB_TIMEOUT_EN undefined: no counter; timeout_err tied 0; grant held until req_last byte.
// TESTING
//  1) Req0 sends "A","B"(last), tx_busy high 10 cycles per byte -> tx_start twice, data 0x41,0x42; grant released.
//  2) req_valid=4'b1011 from reset, each 1-byte msg -> grant order 0,1,3; then req0 again -> after 3.
//  3) Req2 owns, req1 valid mid-message -> req1 ready stays 0 until req2 last byte issued, then grant_id=1.
//  4) tx_busy never asserts after tx_start -> exactly one tx_start per byte, 2-cycle ISSUE_WAIT exit.
//  5) rst_n low during ISSUE_WAIT -> all outputs 0 immediately, next grant goes to requester 0.
//  6) With TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: owner stalls after byte 1 -> timeout_err at cycle 16,
//     grant moves to waiting requester; without macro grant persists past 1000 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte handshakes, UART TX core hookup and grant status for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic [8*NUM_REQ-1:0] req_data;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy;
  logic grant_valid;
  logic [ID_W-1:0] grant_id;
  logic timeout_err;
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input req_ready, tx_data, tx_start, grant_valid, grant_id, timeout_err
  );
  modport slave (
    input req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, grant_valid, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked sharing of one UART TX core among NUM_REQ requesters.
// Define TX_ARB_TIMEOUT_EN to force-release an owner that stalls for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arbiter_if.slave arb
);
  typedef enum logic [1:0] {IDLE, LOCKED, ISSUE_WAIT} state_t;
  state_t r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_win;
  logic [ID_W-1:0] w_idx;
  logic w_any;
  logic w_own_valid;
  logic r_last;
  logic r_wait;
  assign w_own_valid = arb.req_valid[arb.grant_id];
  // Farthest offset scanned first so the nearest requester after r_rr_ptr overrides it.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (arb.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end
`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_to_cnt;
`else
  assign arb.timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
      r_last <= 1'b0;
      r_wait <= 1'b0;
      arb.req_ready <= '0;
      arb.tx_data <= '0;
      arb.tx_start <= 1'b0;
      arb.grant_valid <= 1'b0;
      arb.grant_id <= '0;
`ifdef TX_ARB_TIMEOUT_EN
      r_to_cnt <= '0;
      arb.timeout_err <= 1'b0;
`endif
    end else begin
      arb.req_ready <= '0;
      arb.tx_start <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      arb.timeout_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            arb.grant_valid <= 1'b1;
            arb.grant_id <= w_win;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_own_valid && !arb.tx_busy) begin
            arb.tx_data <= arb.req_data[{arb.grant_id, 3'b000} +: 8];
            arb.tx_start <= 1'b1;
            arb.req_ready <= NUM_REQ'(1) << arb.grant_id;
            r_last <= arb.req_last[arb.grant_id];
            r_wait <= 1'b0;
            r_state <= ISSUE_WAIT;
`ifdef TX_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
          end else if (!w_own_valid) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              r_to_cnt <= '0;
              arb.timeout_err <= 1'b1;
              arb.grant_valid <= 1'b0;
              r_rr_ptr <= arb.grant_id;
              r_state <= IDLE;
            end
`endif
          end
        end
        ISSUE_WAIT: begin
          // Second cycle exits even without busy, so a core that never raises busy cannot stall us.
          r_wait <= 1'b1;
          if (arb.tx_busy || r_wait) begin
            r_state <= r_last ? IDLE : LOCKED;
            arb.grant_valid <= !r_last;
            if (r_last) r_rr_ptr <= arb.grant_id;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
